// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for RV32I loads and stores
//   - LSU control state encodings
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_format.sv
// Combinational data formatting for the load/store unit.
// Ports:
//   funct3      access size/signedness (B, H, W, BU, HU)
//   isStore     1 = store formatting, 0 = load formatting
//   off         byte offset within the word (address bits [1:0])
//   storeData   raw rs2 value
//   readWord    raw word returned by data memory
//   laneData    store data replicated across the byte lanes
//   byteEnable  store byte enables (all ones for loads)
//   loadData    extracted and sign/zero-extended load result
module mem_stage_lsu_format
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        isStore,
    input  logic [1:0]  off,
    input  logic [31:0] storeData,
    input  logic [31:0] readWord,
    output logic [31:0] laneData,
    output logic [3:0]  byteEnable,
    output logic [31:0] loadData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Stores replicate the datum into every lane it could land in, so the
    // memory only has to honour the byte enables. Loads pull the addressed
    // lane back out and extend it to a full register.
    always_comb begin
        byteLane   = readWord[{off, 3'b000} +: 8];
        halfLane   = readWord[{off[1], 4'b0000} +: 16];
        laneData   = 32'h0;
        byteEnable = isStore ? 4'b0000 : 4'b1111;
        loadData   = 32'h0;
        case (funct3)
            F3_B: begin
                if (isStore) begin
                    laneData   = {4{storeData[7:0]}};
                    byteEnable = 4'b0001 << off;
                end
                loadData = {{24{byteLane[7]}}, byteLane};
            end
            F3_H: begin
                if (isStore) begin
                    laneData   = {2{storeData[15:0]}};
                    byteEnable = 4'b0011 << off;
                end
                loadData = {{16{halfLane[15]}}, halfLane};
            end
            F3_W: begin
                if (isStore) begin
                    laneData   = storeData;
                    byteEnable = 4'b1111;
                end
                loadData = readWord;
            end
            F3_BU:   loadData = {24'h0, byteLane};
            F3_HU:   loadData = {16'h0, halfLane};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with MEM/WB pipeline register.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   valid_m .. PCPlus4M          EX/MEM register outputs for the MEM slot
//   dmem_req/we/addr/be/wdata    data-memory request, held until dmem_ack
//   dmem_ack, dmem_rdata         memory completion and read word
//   stall_m                      hold IF/ID/EX/MEM while an access is pending
//   fault_m                      one-cycle pulse on bad access or timeout
//   *W                           MEM/WB register feeding writeback
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic        reg_write_m,
    input  logic [1:0]  result_src_m,
    input  logic [31:0] ALUresultM,
    input  logic [31:0] writedataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        fault_m,
    output logic [31:0] ALUresultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state, stateNext;
    logic [CW-1:0] cnt;
    logic [1:0]    off;
    logic          acc, isStore, f3Legal, misaligned, bad, timedOut;
    logic          startAccess, wCapture, captureLoad, faultNext;
    logic [31:0]   laneData, loadData;
    logic [3:0]    byteEnable;

    assign off      = ALUresultM[1:0];
    assign isStore  = mem_write_m;
    assign acc      = valid_m & (mem_read_m | mem_write_m);
    assign timedOut = (state == LSU_BUSY) && !dmem_ack && (cnt == LAST);

    // The MEM-stage inputs stay frozen while stalled, so one formatter on
    // the live inputs serves both the store issue and the load return.
    mem_stage_lsu_format uFormat (
        .funct3     (funct3_m),
        .isStore    (isStore),
        .off        (off),
        .storeData  (writedataM),
        .readWord   (dmem_rdata),
        .laneData   (laneData),
        .byteEnable (byteEnable),
        .loadData   (loadData)
    );

    // Screen the access before issuing: illegal size for the direction,
    // or an address not aligned to the access size.
    always_comb begin
        f3Legal    = 1'b0;
        misaligned = 1'b0;
        case (funct3_m)
            F3_B:    f3Legal = 1'b1;
            F3_H:    begin f3Legal = 1'b1;     misaligned = off[0];          end
            F3_W:    begin f3Legal = 1'b1;     misaligned = (off != 2'b00);  end
            F3_BU:   f3Legal = !isStore;
            F3_HU:   begin f3Legal = !isStore; misaligned = off[0];          end
            default: ;
        endcase
        bad = !f3Legal || misaligned;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= LSU_IDLE;
        else       state <= stateNext;
    end

    // Next state: a good access parks us in BUSY until ack or timeout.
    always_comb begin
        stateNext = state;
        case (state)
            LSU_IDLE: if (acc && !bad)            stateNext = LSU_BUSY;
            LSU_BUSY: if (dmem_ack || timedOut)   stateNext = LSU_IDLE;
            default:                              stateNext = LSU_IDLE;
        endcase
    end

    // Outputs/controls. The timeout cycle releases the stall so the dead
    // instruction drains out of MEM as a bubble alongside the fault.
    always_comb begin
        stall_m     = 1'b0;
        startAccess = 1'b0;
        wCapture    = 1'b0;
        captureLoad = 1'b0;
        faultNext   = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (!acc)      wCapture  = 1'b1;
                else if (bad)  faultNext = 1'b1;
                else begin
                    stall_m     = 1'b1;
                    startAccess = 1'b1;
                end
            end
            LSU_BUSY: begin
                stall_m = !dmem_ack && !timedOut;
                if (dmem_ack) begin
                    wCapture    = 1'b1;
                    captureLoad = !dmem_we;
                end else if (timedOut) begin
                    faultNext = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Memory request registers, timeout counter and MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
            fault_m    <= 1'b0;
            cnt        <= '0;
            ALUresultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            RdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            fault_m <= faultNext;
            if (startAccess) begin
                dmem_req   <= 1'b1;
                dmem_we    <= isStore;
                dmem_addr  <= {ALUresultM[31:2], 2'b00};
                dmem_be    <= byteEnable;
                dmem_wdata <= laneData;
                cnt        <= '0;
            end else if (state == LSU_BUSY) begin
                if (dmem_ack || timedOut) dmem_req <= 1'b0;
                else                      cnt      <= cnt + CW'(1);
            end
            if (wCapture) begin
                ALUresultW <= ALUresultM;
                ReadDataW  <= captureLoad ? loadData : 32'h0;
                PCPlus4W   <= PCPlus4M;
                RdW        <= RdM;
                RegWriteW  <= reg_write_m;
                ResultSrcW <= result_src_m;
            end else begin
                ALUresultW <= 32'h0;
                ReadDataW  <= 32'h0;
                PCPlus4W   <= 32'h0;
                RdW        <= 5'd0;
                RegWriteW  <= 1'b0;
                ResultSrcW <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: each instruction pushes its
// expected MEM/WB contents into a scoreboard and the entry is popped and
// compared on the edge where the instruction leaves MEM.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_m, mem_read_m, mem_write_m, reg_write_m;
    logic [2:0]  funct3_m;
    logic [1:0]  result_src_m;
    logic [31:0] ALUresultM, writedataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_m, fault_m;
    logic [31:0] ALUresultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    typedef struct {
        logic        bubble;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
    } wExp_t;

    wExp_t       scoreboard[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pcCounter = 32'h0000_1000;

    always #5 clock = ~clock;

    mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_m      (valid_m),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .ALUresultM   (ALUresultM),
        .writedataM   (writedataM),
        .RdM          (RdM),
        .PCPlus4M     (PCPlus4M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall_m      (stall_m),
        .fault_m      (fault_m),
        .ALUresultW   (ALUresultW),
        .ReadDataW    (ReadDataW),
        .PCPlus4W     (PCPlus4W),
        .RdW          (RdW),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one instruction into MEM and follow it until it leaves.
    // ackDelay = BUSY cycles without ack before acking (-1: never ack).
    task automatic applyStimulus(
        input string       name,
        input logic [2:0]  f3,
        input logic        rd_,
        input logic        wr,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input logic        rw,
        input int          ackDelay,
        input logic [31:0] rword,
        input logic        expReq,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata,
        input int          expStalls,
        input logic        expFault,
        input logic [31:0] expReadData
    );
        wExp_t e;
        int    busy = 0;
        int    stalls = 0;
        int    cyc = 0;
        bit    leaving = 0;
        bit    sawReq = 0;

        @(negedge clock);
        valid_m      = 1'b1;
        mem_read_m   = rd_;
        mem_write_m  = wr;
        funct3_m     = f3;
        reg_write_m  = rw;
        result_src_m = rd_ ? 2'b01 : 2'b00;
        ALUresultM   = addr;
        writedataM   = wdata;
        RdM          = rd;
        PCPlus4M     = pcCounter;
        dmem_ack     = 1'b0;

        e.bubble = expFault;
        e.alu    = addr;
        e.rdata  = expReadData;
        e.pc     = pcCounter;
        e.rd     = expFault ? 5'd0 : rd;
        e.rw     = expFault ? 1'b0 : rw;
        e.src    = rd_ ? 2'b01 : 2'b00;
        scoreboard.push_back(e);
        pcCounter = pcCounter + 32'd4;

        while (!leaving && cyc < 40) begin
            cyc++;
            if (dmem_req) begin
                busy++;
                if (!sawReq) begin
                    sawReq = 1;
                    checkOutput({name, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
                    checkOutput({name, ".we"}, 32'(dmem_we), 32'(wr));
                    checkOutput({name, ".be"}, 32'(dmem_be), 32'(expBe));
                    if (wr) checkOutput({name, ".wdata"}, dmem_wdata, expWdata);
                end
                if (ackDelay >= 0 && busy > ackDelay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rword;
                end
            end
            #1;
            if (stall_m) stalls++;
            else         leaving = 1;
            @(posedge clock);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hFFFF_FFFF;
            if (!leaving) begin
                checkOutput({name, ".bubbleRW"}, 32'(RegWriteW), 32'd0);
                @(negedge clock);
            end
        end

        valid_m     = 1'b0;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;

        if (!leaving) checkOutput({name, ".budget"}, 32'd0, 32'd1);
        checkOutput({name, ".stalls"}, 32'(stalls), 32'(expStalls));
        checkOutput({name, ".reqSeen"}, 32'(sawReq), 32'(expReq));
        checkOutput({name, ".fault"}, 32'(fault_m), 32'(expFault));
        checkOutput({name, ".reqDrop"}, 32'(dmem_req), 32'd0);

        e = scoreboard.pop_front();
        checkOutput({name, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
        checkOutput({name, ".RdW"}, 32'(RdW), 32'(e.rd));
        if (!e.bubble) begin
            checkOutput({name, ".ALUresultW"}, ALUresultW, e.alu);
            checkOutput({name, ".ReadDataW"}, ReadDataW, e.rdata);
            checkOutput({name, ".PCPlus4W"}, PCPlus4W, e.pc);
            checkOutput({name, ".ResultSrcW"}, 32'(ResultSrcW), 32'(e.src));
        end
        if (expFault) begin
            @(posedge clock);
            #1;
            checkOutput({name, ".faultPulse"}, 32'(fault_m), 32'd0);
        end
    endtask

    // Start a load, then pull reset while it is outstanding.
    task automatic resetInBusy();
        @(negedge clock);
        valid_m     = 1'b1;
        mem_read_m  = 1'b1;
        mem_write_m = 1'b0;
        funct3_m    = F3_W;
        reg_write_m = 1'b1;
        ALUresultM  = 32'h0000_0300;
        RdM         = 5'd3;
        dmem_ack    = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst.reqUp", 32'(dmem_req), 32'd1);
        @(negedge clock);
        reset   = 1'b1;
        valid_m = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst.req", 32'(dmem_req), 32'd0);
        checkOutput("rst.RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("rst.ALUresultW", ALUresultW, 32'd0);
        checkOutput("rst.fault", 32'(fault_m), 32'd0);
        checkOutput("rst.stall", 32'(stall_m), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst.faultAfter", 32'(fault_m), 32'd0);
        checkOutput("rst.reqAfter", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        valid_m      = 1'b0;
        mem_read_m   = 1'b0;
        mem_write_m  = 1'b0;
        funct3_m     = 3'b000;
        reg_write_m  = 1'b0;
        result_src_m = 2'b00;
        ALUresultM   = 32'h0;
        writedataM   = 32'h0;
        RdM          = 5'd0;
        PCPlus4M     = 32'h0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.req", 32'(dmem_req), 32'd0);
        checkOutput("reset.be", 32'(dmem_be), 32'd0);
        checkOutput("reset.addr", dmem_addr, 32'd0);
        checkOutput("reset.RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("reset.ALUresultW", ALUresultW, 32'd0);
        checkOutput("reset.fault", 32'(fault_m), 32'd0);
        checkOutput("reset.stall", 32'(stall_m), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        //            name    f3     rd wr addr          wdata         rd    rw ack rword         req be       expWdata      st flt readData
        applyStimulus("alu",  F3_B,  0, 0, 32'h0000_1234, 32'h0,        5'd5, 1, -1, 32'h0,        0,  4'b0000, 32'h0,        0, 0, 32'h0);
        applyStimulus("sw",   F3_W,  0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 0, 3, 32'h0,        1,  4'b1111, 32'hDEAD_BEEF, 4, 0, 32'h0);
        applyStimulus("lb",   F3_B,  1, 0, 32'h0000_0203, 32'h0,        5'd10,1, 1, 32'h80FF_1234, 1,  4'b1111, 32'h0,        2, 0, 32'hFFFF_FF80);
        applyStimulus("lbu",  F3_BU, 1, 0, 32'h0000_0203, 32'h0,        5'd11,1, 1, 32'h80FF_1234, 1,  4'b1111, 32'h0,        2, 0, 32'h0000_0080);
        applyStimulus("sh",   F3_H,  0, 1, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 0, 0, 32'h0,        1,  4'b1100, 32'hABCD_ABCD, 1, 0, 32'h0);
        applyStimulus("lhu",  F3_HU, 1, 0, 32'h0000_0102, 32'h0,        5'd12,1, 0, 32'hABCD_0000, 1,  4'b1111, 32'h0,        1, 0, 32'h0000_ABCD);
        applyStimulus("lh",   F3_H,  1, 0, 32'h0000_0100, 32'h0,        5'd13,1, 2, 32'h1234_8001, 1,  4'b1111, 32'h0,        3, 0, 32'hFFFF_8001);
        applyStimulus("sb",   F3_B,  0, 1, 32'h0000_0101, 32'h0000_005A, 5'd0, 0, 0, 32'h0,        1,  4'b0010, 32'h5A5A_5A5A, 1, 0, 32'h0);
        applyStimulus("lwMis",F3_W,  1, 0, 32'h0000_0101, 32'h0,        5'd14,1, -1, 32'h0,        0,  4'b0000, 32'h0,        0, 1, 32'h0);
        applyStimulus("sbu",  F3_BU, 0, 1, 32'h0000_0100, 32'h0,        5'd0, 0, -1, 32'h0,        0,  4'b0000, 32'h0,        0, 1, 32'h0);
        applyStimulus("lwTo", F3_W,  1, 0, 32'h0000_0100, 32'h0,        5'd15,1, -1, 32'h0,        1,  4'b1111, 32'h0,        4, 1, 32'h0);
        applyStimulus("lwOk", F3_W,  1, 0, 32'h0000_0104, 32'h0,        5'd16,1, 0, 32'hCAFE_F00D, 1,  4'b1111, 32'h0,        1, 0, 32'hCAFE_F00D);
        resetInBusy();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
